// File: rtl/am_pkg.sv
// Shared types and constants for the AM measurement path.
package am_pkg;

  localparam int unsigned CODE_W   = 10;   // demodulator code width
  localparam int unsigned ENV_W    = 11;   // signed envelope width
  localparam int unsigned NUM_W    = 17;   // depth numerator width
  localparam int unsigned DEN_W    = 11;   // depth denominator width
  localparam int unsigned MIDSCALE = 512;
  localparam int unsigned MA_MAX   = 100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_PEAK   = 3'd2,
    ST_COUNT  = 3'd3,
    ST_DIV    = 3'd4,
    ST_DONE   = 3'd5
  } am_state_e;

  // Offset-binary code to envelope magnitude; below-midscale samples read as 0.
  function automatic logic [CODE_W-1:0] env_clamp(input logic [CODE_W-1:0] code);
    logic [ENV_W-1:0] e;
    e = ENV_W'(code) - ENV_W'(MIDSCALE);
    return e[ENV_W-1] ? '0 : CODE_W'(e);
  endfunction

endpackage

// File: rtl/serial_div.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses NUM_W cycles after go.
module serial_div #(
  parameter int unsigned NUM_W = 17,
  parameter int unsigned DEN_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [NUM_W-1:0] quo
);

  localparam int unsigned CNT_W = $clog2(NUM_W + 1);

  logic [DEN_W-1:0] rem_q;
  logic [DEN_W-1:0] den_q;
  logic [CNT_W-1:0] steps_q;
  logic             running_q;

  logic [DEN_W-1:0] rem_src;
  logic [DEN_W-1:0] den_src;
  logic [NUM_W-1:0] nq_src;
  logic [DEN_W:0]   trial;
  logic             take;
  logic [DEN_W-1:0] rem_nxt;
  logic [NUM_W-1:0] nq_nxt;

  // One restoring step; the first step runs on the go cycle straight from the operands.
  always_comb begin
    rem_src = go ? '0 : rem_q;
    nq_src  = go ? num : quo;
    den_src = go ? den : den_q;
    trial   = {rem_src, nq_src[NUM_W-1]};
    take    = (den_src != '0) && (trial >= {1'b0, den_src});
    rem_nxt = take ? DEN_W'(trial - {1'b0, den_src}) : DEN_W'(trial);
    nq_nxt  = {nq_src[NUM_W-2:0], take};
  end

  // Quotient shifts in from the LSB while the numerator shifts out of the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q     <= '0;
      den_q     <= '0;
      quo       <= '0;
      steps_q   <= '0;
      running_q <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        rem_q     <= rem_nxt;
        quo       <= nq_nxt;
        den_q     <= den;
        steps_q   <= CNT_W'(NUM_W - 1);
        running_q <= 1'b1;
      end else if (running_q) begin
        rem_q   <= rem_nxt;
        quo     <= nq_nxt;
        steps_q <= steps_q - CNT_W'(1);
        if (steps_q == CNT_W'(1)) begin
          running_q <= 1'b0;
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/am_meas_ctrl.sv
// AM measurement sequencer: settle, peak/trough window, crossing-count window, depth divide.
module am_meas_ctrl
  import am_pkg::*;
#(
  parameter int unsigned WIN_LEN    = 8192,
  parameter int unsigned SETTLE_CYC = 256,
  parameter int unsigned HYST       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic [CODE_W-1:0] demod_in,
  input  logic              demod_valid,
  output logic              demod_en,
  output logic              busy,
  output logic              meas_valid,
  output logic [7:0]        ma,
  output logic [7:0]        freq
);

  localparam int unsigned TMR_MAX = (WIN_LEN > SETTLE_CYC) ? WIN_LEN : SETTLE_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX);
  localparam logic [DEN_W-1:0] HYST_V = DEN_W'(HYST);

  am_state_e state, state_nxt;

  logic [TMR_W-1:0]  tmr_q;
  logic [TMR_W-1:0]  tmr_reload;
  logic              tmr_last;

  logic [CODE_W-1:0] env;
  logic [CODE_W-1:0] emax_q, emin_q, mid_q;
  logic              seen_q;
  logic [CODE_W-1:0] emax_upd, emin_upd;
  logic              seen_upd;
  logic [CODE_W-1:0] fin_max, fin_min;
  logic [DEN_W-1:0]  fin_sum;

  logic              armed_q;
  logic [8:0]        cnt_q;
  logic              below, above;

  logic              peak_entry, count_entry;

  logic              div_go, div_done;
  logic [NUM_W-1:0]  div_num, div_quo;
  logic [DEN_W-1:0]  div_den;
  logic [7:0]        ma_sat;

  assign tmr_last    = (tmr_q == '0);
  assign env         = env_clamp(demod_in);
  assign peak_entry  = (state_nxt == ST_PEAK)  && (state != ST_PEAK);
  assign count_entry = (state_nxt == ST_COUNT) && (state != ST_COUNT);

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start)    state_nxt = ST_SETTLE;
      ST_SETTLE: if (tmr_last) state_nxt = ST_PEAK;
      ST_PEAK:   if (tmr_last) state_nxt = ST_COUNT;
      ST_COUNT:  if (tmr_last) state_nxt = ST_DIV;
      ST_DIV:    if (div_done) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = cont ? ST_PEAK : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Reload value of the shared down-counter for the state being entered.
  always_comb begin
    tmr_reload = '0;
    case (state_nxt)
      ST_SETTLE:        tmr_reload = TMR_W'(SETTLE_CYC - 1);
      ST_PEAK, ST_COUNT: tmr_reload = TMR_W'(WIN_LEN - 1);
      default:          tmr_reload = '0;
    endcase
  end

  // Shared settle/window down-counter, reloaded on every state change.
  always_ff @(posedge clk) begin
    if (rst)                     tmr_q <= '0;
    else if (state_nxt != state) tmr_q <= tmr_reload;
    else if (!tmr_last)          tmr_q <= tmr_q - TMR_W'(1);
  end

  // Extrema including the current sample, so the last PEAK cycle still counts.
  always_comb begin
    emax_upd = (demod_valid && (env > emax_q)) ? env : emax_q;
    emin_upd = (demod_valid && (env < emin_q)) ? env : emin_q;
    seen_upd = seen_q | demod_valid;
    fin_max  = seen_upd ? emax_upd : '0;
    fin_min  = seen_upd ? emin_upd : '0;
    fin_sum  = DEN_W'(fin_max) + DEN_W'(fin_min);
  end

  // Peak/trough capture and midpoint latch at window end.
  always_ff @(posedge clk) begin
    if (rst) begin
      emax_q <= '0;
      emin_q <= '0;
      seen_q <= 1'b0;
      mid_q  <= '0;
    end else if (peak_entry) begin
      emax_q <= '0;
      emin_q <= '1;
      seen_q <= 1'b0;
    end else if (state == ST_PEAK) begin
      seen_q <= seen_upd;
      if (tmr_last) begin
        emax_q <= fin_max;
        emin_q <= fin_min;
        mid_q  <= fin_sum[DEN_W-1:1];
      end else begin
        emax_q <= emax_upd;
        emin_q <= emin_upd;
      end
    end
  end

  // Hysteresis thresholds, kept unsigned by moving HYST to the other side.
  always_comb begin
    below = (DEN_W'(env) + HYST_V) < DEN_W'(mid_q);
    above = DEN_W'(env) > (DEN_W'(mid_q) + HYST_V);
  end

  // Arm below the low threshold, count on the next rise above the high one.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else if (count_entry) begin
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else if ((state == ST_COUNT) && demod_valid) begin
      if (below) begin
        armed_q <= 1'b1;
      end else if (above && armed_q) begin
        armed_q <= 1'b0;
        if (cnt_q < 9'd255) cnt_q <= cnt_q + 9'd1;
      end
    end
  end

  // Divide launches on the last COUNT cycle so the quotient lands as DIV ends.
  assign div_go  = (state == ST_COUNT) && tmr_last;
  assign div_num = NUM_W'(emax_q - emin_q) * NUM_W'(MA_MAX);
  assign div_den = DEN_W'(emax_q) + DEN_W'(emin_q);

  serial_div #(
    .NUM_W (NUM_W),
    .DEN_W (DEN_W)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .go   (div_go),
    .num  (div_num),
    .den  (div_den),
    .done (div_done),
    .quo  (div_quo)
  );

  assign ma_sat = (div_quo > NUM_W'(MA_MAX)) ? 8'(MA_MAX) : 8'(div_quo);

  // Registered outputs, driven from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      demod_en   <= 1'b0;
      busy       <= 1'b0;
      meas_valid <= 1'b0;
      ma         <= '0;
      freq       <= '0;
    end else begin
      demod_en   <= (state_nxt != ST_IDLE);
      busy       <= (state_nxt != ST_IDLE);
      meas_valid <= (state_nxt == ST_DONE);
      if (state_nxt == ST_DONE) begin
        ma   <= ma_sat;
        freq <= (cnt_q > 9'd255) ? 8'd255 : cnt_q[7:0];
      end
    end
  end

endmodule

// File: tb/tb_am_meas_ctrl.sv
// Randomized scoreboard bench for am_meas_ctrl against a window-level reference model.
module tb_am_meas_ctrl;

  localparam int W   = 1024;
  localparam int S   = 32;
  localparam int H   = 8;
  localparam int LAT = 2 * W + 17;   // first PEAK cycle to meas_valid

  localparam int K_TONE   = 0;
  localparam int K_SQUARE = 1;
  localparam int K_NOISE  = 2;

  typedef int iq_t[$];
  typedef struct {
    int    cyc;
    int    ma;
    int    freq;
    string name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cont;
  logic [9:0] demod_in;
  logic       demod_valid;
  logic       demod_en;
  logic       busy;
  logic       meas_valid;
  logic [7:0] ma;
  logic [7:0] freq;

  always #5 clk = ~clk;

  am_meas_ctrl #(
    .WIN_LEN    (W),
    .SETTLE_CYC (S),
    .HYST       (H)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cont        (cont),
    .demod_in    (demod_in),
    .demod_valid (demod_valid),
    .demod_en    (demod_en),
    .busy        (busy),
    .meas_valid  (meas_valid),
    .ma          (ma),
    .freq        (freq)
  );

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   last_ma = 0;
  int   last_freq = 0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic int env_of(input int code);
    return (code > 512) ? code - 512 : 0;
  endfunction

  function automatic int gen(input int kind, input int dc, input int amp, input int per, input int k);
    int v;
    case (kind)
      K_TONE:   v = 512 + dc + int'(real'(amp) * $sin(6.283185307179586 * real'(k) / real'(per)));
      K_SQUARE: v = ((k % 2) == 0) ? 512 + dc + amp : 512 + dc - amp;
      default:  v = 512 + dc + int'($urandom_range(0, 2 * amp)) - amp;
    endcase
    if (v < 0)    v = 0;
    if (v > 1023) v = 1023;
    return v;
  endfunction

  // Window-level model: extrema of the first window, hysteresis crossings of the second.
  function automatic void model(input iq_t pk, input iq_t ct, output int ma_e, output int fr_e);
    int  mx, mn, mid, c;
    bit  armed;
    mx = 0; mn = 0; c = 0; armed = 0;
    if (pk.size() > 0) begin
      mx = pk[0]; mn = pk[0];
      foreach (pk[i]) begin
        if (pk[i] > mx) mx = pk[i];
        if (pk[i] < mn) mn = pk[i];
      end
    end
    mid = (mx + mn) / 2;
    foreach (ct[i]) begin
      if (ct[i] < mid - H) armed = 1;
      else if (armed && ct[i] > mid + H) begin
        c++;
        armed = 0;
      end
    end
    fr_e = (c > 255) ? 255 : c;
    if (mx + mn == 0) ma_e = 0;
    else ma_e = ((mx - mn) * 100) / (mx + mn);
    if (ma_e > 100) ma_e = 100;
  endfunction

  // Monitor: outputs during reset, scoreboard pops on meas_valid, hold otherwise.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        check("rst_ma", int'(ma), 0);
        check("rst_freq", int'(freq), 0);
        check("rst_meas_valid", int'(meas_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_demod_en", int'(demod_en), 0);
        last_ma = 0;
        last_freq = 0;
      end else if (meas_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_meas_valid", 1, 0);
        end else begin
          x = sb.pop_front();
          check({x.name, "_cycle"}, cyc, x.cyc);
          check({x.name, "_ma"}, int'(ma), x.ma);
          check({x.name, "_freq"}, int'(freq), x.freq);
        end
        last_ma = int'(ma);
        last_freq = int'(freq);
      end else begin
        check("hold_ma", int'(ma), last_ma);
        check("hold_freq", int'(freq), last_freq);
      end
    end
  end

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_start(output int t);
    check("idle_busy", int'(busy), 0);
    start = 1'b1;
    t = cyc;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", int'(busy), 1);
    check("start_demod_en", int'(demod_en), 1);
  endtask

  // Drive samples up to the end of COUNT for a measurement whose PEAK starts at peak_start.
  task automatic run_one(input string name, input int kind, input int dc, input int amp,
                         input int per, input int vprob, input bit cont_val, input bit poke,
                         input int peak_start);
    iq_t  pk;
    iq_t  ct;
    int   k, code, ma_e, fr_e;
    bit   v;
    exp_t x;
    while (cyc < peak_start + 2 * W) begin
      k = cyc;
      code = gen(kind, dc, amp, per, k);
      v = ($urandom_range(0, 99) < vprob);
      demod_in = 10'(code);
      demod_valid = v;
      if (k == peak_start) cont = cont_val;
      start = poke && (k == peak_start + W / 2);
      if (v && k >= peak_start && k < peak_start + W) pk.push_back(env_of(code));
      else if (v && k >= peak_start + W) ct.push_back(env_of(code));
      @(negedge clk);
    end
    start = 1'b0;
    model(pk, ct, ma_e, fr_e);
    x.cyc = peak_start + LAT;
    x.ma = ma_e;
    x.freq = fr_e;
    x.name = name;
    sb.push_back(x);
  endtask

  // Single-shot measurement followed by a return-to-idle check.
  task automatic measure(input string name, input int kind, input int dc, input int amp,
                         input int per, input int vprob);
    int t, p;
    do_start(t);
    p = t + 1 + S;
    run_one(name, kind, dc, amp, per, vprob, 1'b0, 1'b0, p);
    wait_to(p + LAT + 1);
    check({name, "_idle_after"}, int'(busy), 0);
  endtask

  initial begin
    int t, p, dc, amp, per, vp;
    rst = 1'b1;
    start = 1'b0;
    cont = 1'b0;
    demod_in = 10'd512;
    demod_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_demod_en", int'(demod_en), 0);

    measure("tone2k",   K_TONE,   300, 150, 512, 100);
    measure("tone100",  K_TONE,   250, 250, 205, 100);
    measure("tone120",  K_TONE,   200, 240, 205, 100);
    measure("const512", K_TONE,   0,   0,   100, 100);
    measure("const700", K_TONE,   188, 0,   100, 100);
    measure("noise",    K_NOISE,  200, H - 1, 1, 100);
    measure("square",   K_SQUARE, 200, 100, 2,   100);
    measure("novalid",  K_TONE,   300, 150, 300, 0);
    for (int i = 0; i < 4; i++) begin
      dc  = int'($urandom_range(50, 400));
      amp = int'($urandom_range(0, 300));
      per = int'($urandom_range(40, 600));
      vp  = int'($urandom_range(30, 100));
      measure("rand", K_TONE, dc, amp, per, vp);
    end

    // Reset in the middle of COUNT: no result, outputs cleared, demod disabled.
    measure("pre_rst", K_TONE, 300, 150, 512, 100);
    do_start(t);
    p = t + 1 + S;
    demod_in = 10'd800;
    demod_valid = 1'b1;
    wait_to(p + W + 100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", int'(busy), 0);
    check("midrst_demod_en", int'(demod_en), 0);
    check("midrst_ma", int'(ma), 0);
    check("midrst_freq", int'(freq), 0);
    wait_to(p + LAT + 50);

    // Continuous mode with an ignored start pulse, then cont dropped on the last pass.
    do_start(t);
    p = t + 1 + S;
    run_one("cont1", K_TONE, 300, 200, 341, 100, 1'b1, 1'b0, p);
    run_one("cont2", K_TONE, 300, 200, 341, 100, 1'b1, 1'b1, p + LAT + 1);
    run_one("cont3", K_TONE, 300, 200, 341, 100, 1'b0, 1'b0, p + 2 * (LAT + 1));
    wait_to(p + 2 * (LAT + 1) + LAT + 1);
    check("cont_idle_busy", int'(busy), 0);
    check("cont_idle_demod_en", int'(demod_en), 0);

    repeat (40) @(negedge clk);
    if (sb.size() != 0) check("scoreboard_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
